// File: rtl/rf_sb.sv
// rf_sb: MIPS register file with per-register busy scoreboard, issue permit and busy counter.
// Define RF_BYPASS_EN to forward the write-back value/readiness within the write-back cycle.
module rf_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic              rdyA,
  output logic              rdyB,
  input  logic              RegWr,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] busW,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic              iss_use_a,
  input  logic              iss_use_b,
  output logic              iss_ok,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_busyCnt;

  logic             w_wrEn;
  logic             w_hitA;
  logic             w_hitB;
  logic             w_hitDst;
  logic             w_dfree;
  logic             w_set;
  logic             w_inc;
  logic             w_dec;
  logic [DEPTH-1:0] w_clrMask;
  logic [DEPTH-1:0] w_setMask;
  logic [DEPTH-1:0] w_busyNext;

  assign w_wrEn = RegWr && (RW != '0);

`ifdef RF_BYPASS_EN
  assign w_hitA   = w_wrEn && (RW == RA);
  assign w_hitB   = w_wrEn && (RW == RB);
  assign w_hitDst = RegWr && (RW == iss_dst);
`else
  assign w_hitA   = 1'b0;
  assign w_hitB   = 1'b0;
  assign w_hitDst = 1'b0;
`endif

  always_comb begin
    busA = '0;
    if (w_hitA)
      busA = busW;
    else if (RA != '0)
      busA = r_regs[RA];
  end

  always_comb begin
    busB = '0;
    if (w_hitB)
      busB = busW;
    else if (RB != '0)
      busB = r_regs[RB];
  end

  // Register 0 is never set busy, so no special case is needed for it here.
  assign rdyA = !r_busy[RA] || w_hitA;
  assign rdyB = !r_busy[RB] || w_hitB;

  assign w_dfree = (iss_dst == '0) || !r_busy[iss_dst] || w_hitDst;
  assign iss_ok  = w_dfree && (!iss_use_a || rdyA) && (!iss_use_b || rdyB);
  assign w_set   = iss_valid && iss_ok && (iss_dst != '0);

  always_comb begin
    w_clrMask = '0;
    w_setMask = '0;
    if (w_wrEn)
      w_clrMask[RW] = 1'b1;
    if (w_set)
      w_setMask[iss_dst] = 1'b1;
  end

  // Set is applied after clear so a same-register issue (newer producer) wins.
  assign w_busyNext = (r_busy & ~w_clrMask) | w_setMask;
  assign w_dec      = w_wrEn && r_busy[RW];
  assign w_inc      = w_set && !(r_busy[iss_dst] && !w_clrMask[iss_dst]);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
      r_busy    <= '0;
      r_busyCnt <= '0;
    end else begin
      if (w_wrEn)
        r_regs[RW] <= busW;
      r_busy    <= w_busyNext;
      r_busyCnt <= r_busyCnt + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
    end
  end

  assign busy_cnt = r_busyCnt;

endmodule
